// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of the ALU: registers one command onto the ALU, captures its
// result and flags, and keeps the architectural carry. Optional invalid-op counter: ALU_ERR_COUNT_EN.
module alu_issue_stage #(
    parameter int BUS_WIDTH = 8
`ifdef ALU_ERR_COUNT_EN
    , parameter int ERR_CNT_WIDTH = 8
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_opcode,
    input  logic [BUS_WIDTH-1:0] cmd_a,
    input  logic [BUS_WIDTH-1:0] cmd_b,
    input  logic                 cmd_carry_clr,
    output logic [3:0]           alu_opcode,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BUS_WIDTH-1:0] res_y,
    output logic [4:0]           res_flags,
    output logic                 carry_flag
`ifdef ALU_ERR_COUNT_EN
    , output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [BUS_WIDTH-1:0] a_q, a_d, b_q, b_d, res_y_q, res_y_d;
    logic                 cin_q, cin_d, clr_q, clr_d, carry_q, carry_d;
    logic [4:0]           flags_q, flags_d;
`ifdef ALU_ERR_COUNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        clr_d   = clr_q;
        res_y_d = res_y_q;
        flags_d = flags_q;
        carry_d = carry_q;
`ifdef ALU_ERR_COUNT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d    = cmd_opcode;
                a_d     = cmd_a;
                b_d     = cmd_b;
                clr_d   = cmd_carry_clr;
                // carry cannot change before E1, so the carry-in can be frozen at accept
                cin_d   = (cmd_opcode == 4'd2) && !cmd_carry_clr && carry_q;
                state_d = EXEC;
            end
            EXEC: begin
                res_y_d = alu_y;
                flags_d = {alu_invalid_op, alu_parity, alu_zero, alu_borrow, alu_carry_out};
                if (!alu_invalid_op) begin
                    case (op_q)
                        4'd1, 4'd2, 4'd4:       carry_d = alu_carry_out;
                        4'd3, 4'd5:             carry_d = alu_borrow;
                        4'd6, 4'd7, 4'd8, 4'd9: if (clr_q) carry_d = 1'b0;
                        default:                carry_d = carry_q;
                    endcase
                end
`ifdef ALU_ERR_COUNT_EN
                if (alu_invalid_op && (err_q != '1)) err_d = err_q + 1'b1;
`endif
                state_d = DONE;
            end
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            clr_q   <= 1'b0;
            res_y_q <= '0;
            flags_q <= '0;
            carry_q <= 1'b0;
`ifdef ALU_ERR_COUNT_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            clr_q   <= clr_d;
            res_y_q <= res_y_d;
            flags_q <= flags_d;
            carry_q <= carry_d;
`ifdef ALU_ERR_COUNT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign res_valid    = (state_q == DONE);
    assign alu_opcode   = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_carry_in = cin_q;
    assign res_y        = res_y_q;
    assign res_flags    = flags_q;
    assign carry_flag   = carry_q;
`ifdef ALU_ERR_COUNT_EN
    assign err_count    = err_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU closing the loop.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_carry_clr = 1'b0;
    logic [3:0] cmd_opcode = '0, alu_opcode;
    logic [7:0] cmd_a = '0, cmd_b = '0, alu_a, alu_b, alu_y, res_y;
    logic       alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
    logic       res_valid, res_ready = 1'b1, carry_flag;
    logic [4:0] res_flags;
`ifdef ALU_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.BUS_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_carry_clr(cmd_carry_clr),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
        .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_flags(res_flags),
        .carry_flag(carry_flag)
`ifdef ALU_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    // behavioural ALU; parity is 1 for an even number of ones
    always_comb begin
        alu_y          = '0;
        alu_carry_out  = 1'b0;
        alu_borrow     = 1'b0;
        alu_invalid_op = 1'b0;
        case (alu_opcode)
            4'd1: {alu_carry_out, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            4'd2: {alu_carry_out, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
            4'd3: begin alu_y = alu_a - alu_b; alu_borrow = (alu_a < alu_b); end
            4'd4: {alu_carry_out, alu_y} = {1'b0, alu_a} + 9'd1;
            4'd5: begin alu_y = alu_a - 8'd1; alu_borrow = (alu_a == 8'd0); end
            4'd6: alu_y = alu_a & alu_b;
            4'd7: alu_y = ~alu_a;
            4'd8: alu_y = {alu_a[6:0], alu_a[7]};
            4'd9: alu_y = {alu_a[0], alu_a[7:1]};
            default: alu_invalid_op = 1'b1;
        endcase
        alu_zero   = (alu_y == 8'd0);
        alu_parity = ~^alu_y;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // starts and ends at a negedge; returns in EXEC
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic clr);
        int n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_carry_clr = clr;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_carry_clr = 1'b0;
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic clr, input logic [7:0] exp_y, input logic exp_cin,
                       input logic exp_cf);
        issue(op, a, b, clr);
        chk("exec_cin", alu_carry_in, exp_cin);
        chk("exec_no_res", res_valid, 0);
        @(negedge clk);
        chk("res_valid", res_valid, 1);
        chk("res_y", res_y, exp_y);
        chk("carry_flag", carry_flag, exp_cf);
        if (res_ready) @(negedge clk);
    endtask

    initial begin
        // 1: reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_alu_op", alu_opcode, 0);
        chk("rst_res_y", res_y, 0);

        // 2: plain add with latency check inside run
        run(4'd1, 8'd9, 8'd33, 1'b0, 8'd42, 1'b0, 1'b0);
        chk("add_flags", res_flags, 5'b00000);
        chk("add_back_idle", cmd_ready, 1);

        // 3: carry chain
        run(4'd1, 8'd200, 8'd100, 1'b0, 8'd44, 1'b0, 1'b1);
        run(4'd2, 8'd1, 8'd2, 1'b0, 8'd4, 1'b1, 1'b0);
        run(4'd1, 8'd200, 8'd100, 1'b0, 8'd44, 1'b0, 1'b1);
        run(4'd2, 8'd1, 8'd2, 1'b1, 8'd3, 1'b0, 1'b0);

        // 4: subtract with back-pressure; stray command ignored
        res_ready = 1'b0;
        run(4'd3, 8'd65, 8'd66, 1'b0, 8'd255, 1'b0, 1'b1);
        chk("sub_borrow", res_flags[1], 1);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 2); cmd_opcode = 4'd6; cmd_a = 8'h11; cmd_b = 8'h22;
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("hold_valid", res_valid, 1);
            chk("hold_y", res_y, 255);
            chk("hold_ready", cmd_ready, 0);
        end
        chk("stray_not_latched", alu_opcode, 3);
        res_ready = 1'b1;
        @(negedge clk);
        chk("release_idle", cmd_ready, 1);
        chk("release_no_res", res_valid, 0);

        // 5: invalid opcodes keep carry (even with clr); AND with clr clears it
        run(4'd0, 8'd5, 8'd6, 1'b1, 8'd0, 1'b0, 1'b1);
        chk("inv0_flag", res_flags[4], 1);
`ifdef ALU_ERR_COUNT_EN
        chk("err_1", err_count, 1);
`endif
        run(4'd12, 8'd5, 8'd6, 1'b0, 8'd0, 1'b0, 1'b1);
        chk("inv12_flag", res_flags[4], 1);
`ifdef ALU_ERR_COUNT_EN
        chk("err_2", err_count, 2);
        for (int i = 0; i < 254; i++) run(4'd15, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        chk("err_sat", err_count, 255);
`endif
        run(4'd6, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0);
        chk("and_valid_op", res_flags[4], 0);

        // 6: reset during EXEC, then during DONE
        run(4'd1, 8'd200, 8'd100, 1'b0, 8'd44, 1'b0, 1'b1);
        issue(4'd1, 8'd1, 8'd2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstx_idle", cmd_ready, 1);
        chk("rstx_no_res", res_valid, 0);
        chk("rstx_carry", carry_flag, 0);
        chk("rstx_alu_op", alu_opcode, 0);
        @(negedge clk);
        chk("rstx_still_no_res", res_valid, 0);

        run(4'd1, 8'd200, 8'd100, 1'b0, 8'd44, 1'b0, 1'b1);
        res_ready = 1'b0;
        run(4'd4, 8'd7, 8'd0, 1'b0, 8'd8, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        res_ready = 1'b1;
        chk("rstd_idle", cmd_ready, 1);
        chk("rstd_no_res", res_valid, 0);
        chk("rstd_res_y", res_y, 0);
        chk("rstd_carry", carry_flag, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
